latsnq_bank_ctl: RTL

- Sequencing controller for a bank of WIDTH latsnq-style set-able latches (D, E, SETN → Q) on a shared D bus.
- Arbitrates NREQ write requesters round-robin and a single bank-preset requester.
- Generates LAT_D / LAT_E / LAT_SETN with guaranteed D-setup before E falls, D-hold after E falls, minimum E and SETN pulse widths, and SETN recovery before the next E.
- All latch-facing outputs are registered (glitch-free) and driven from one clock domain.

---
 rtl/latsnq_bank_ctl_pkg.sv | 35 +++
 rtl/latsnq_bank_rr_arb.sv | 33 +++
 rtl/latsnq_bank_ctl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/latsnq_bank_ctl_pkg.sv
// Shared types and timing defaults for the latsnq latch bank controller.
// Optional shadow model of bank contents: LATSNQ_BANK_CTL_SHADOW_EN.
package latsnq_bank_ctl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_ENABLE  = 3'd2,
    S_HOLD    = 3'd3,
    S_PRESET  = 3'd4,
    S_RECOVER = 3'd5
  } state_t;

  localparam int DEF_NREQ      = 4;
  localparam int DEF_WIDTH     = 8;
  localparam int DEF_SETUP_CYC = 1;
  localparam int DEF_PULSE_CYC = 2;
  localparam int DEF_HOLD_CYC  = 1;
  localparam int DEF_RECOV_CYC = 2;

  function automatic int cnt_w(
    input int a,
    input int b,
    input int c,
    input int d
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/latsnq_bank_rr_arb.sv
// Combinational round-robin pick: first asserted request at or after ptr.
// Pointer state is owned by the parent controller.
module latsnq_bank_rr_arb
  import latsnq_bank_ctl_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx,
  output logic            any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!any && req[j]) begin
        any = 1'b1;
        idx = PW'(j);
      end
    end
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/latsnq_bank_ctl.sv
// Write/preset sequencer for a latsnq latch bank on a shared D bus.
// Define LATSNQ_BANK_CTL_SHADOW_EN to add the shadow_q bank model.
module latsnq_bank_ctl
  import latsnq_bank_ctl_pkg::*;
#(
  parameter int NREQ      = DEF_NREQ,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int PULSE_CYC = DEF_PULSE_CYC,
  parameter int HOLD_CYC  = DEF_HOLD_CYC,
  parameter int RECOV_CYC = DEF_RECOV_CYC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_d,
  input  logic                  preset_req,
  output logic [NREQ-1:0]       gnt,
  output logic                  preset_ack,
  output logic                  done,
  output logic                  busy,
  output logic [WIDTH-1:0]      lat_d,
  output logic                  lat_e,
  output logic                  lat_setn
`ifdef LATSNQ_BANK_CTL_SHADOW_EN
  ,
  output logic [WIDTH-1:0]      shadow_q
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = cnt_w(SETUP_CYC, PULSE_CYC,
                            HOLD_CYC, RECOV_CYC);

  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] RECOV_LD = CW'(RECOV_CYC - 1);

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     ptr_nx;
  logic [NREQ-1:0]   pick;
  logic [PW-1:0]     pick_idx;
  logic              pick_any;
  logic [WIDTH-1:0]  pick_d;
  logic              cnt_zero;

  latsnq_bank_rr_arb #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (pick),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign pick_d   = req_d[int'(pick_idx)*WIDTH +: WIDTH];
  assign ptr_nx   = (int'(pick_idx) == NREQ - 1) ? '0
                  : pick_idx + PW'(1);
  assign cnt_zero = (cnt == '0);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      ptr        <= '0;
      gnt        <= '0;
      done       <= 1'b0;
      preset_ack <= 1'b0;
      lat_d      <= '0;
      lat_e      <= 1'b0;
      lat_setn   <= 1'b1;
    end else begin
      gnt        <= '0;
      done       <= 1'b0;
      preset_ack <= 1'b0;
      unique case (state)
        S_IDLE: begin
          // preset outranks writes
          if (preset_req) begin
            state    <= S_PRESET;
            lat_setn <= 1'b0;
            cnt      <= PULSE_LD;
          end else if (pick_any) begin
            state <= S_SETUP;
            gnt   <= pick;
            lat_d <= pick_d;
            ptr   <= ptr_nx;
            cnt   <= SETUP_LD;
          end
        end
        S_SETUP: begin
          if (cnt_zero) begin
            state <= S_ENABLE;
            lat_e <= 1'b1;
            cnt   <= PULSE_LD;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_ENABLE: begin
          if (cnt_zero) begin
            state <= S_HOLD;
            lat_e <= 1'b0;
            cnt   <= HOLD_LD;
            done  <= (HOLD_CYC == 1);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_HOLD: begin
          if (cnt_zero) begin
            state <= S_IDLE;
          end else begin
            cnt  <= cnt - CW'(1);
            done <= (cnt == CW'(1));
          end
        end
        S_PRESET: begin
          if (cnt_zero) begin
            state      <= S_RECOVER;
            lat_setn   <= 1'b1;
            cnt        <= RECOV_LD;
            preset_ack <= (RECOV_CYC == 1);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_RECOVER: begin
          if (cnt_zero) begin
            state <= S_IDLE;
          end else begin
            cnt        <= cnt - CW'(1);
            preset_ack <= (cnt == CW'(1));
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef LATSNQ_BANK_CTL_SHADOW_EN
  // tracks what the latches hold: loads as E rises, ones as SETN falls
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '1;
    end else if (state == S_SETUP && cnt_zero) begin
      shadow_q <= lat_d;
    end else if (state == S_IDLE && preset_req) begin
      shadow_q <= '1;
    end
  end
`else
`endif

endmodule
